// File: rtl/uart_fc_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_fc_bridge_if
// Handshake bundle between uart_fc_bridge and the host-side logic.
//   rsp_req / rsp_ack / rsp_data : 4-phase channel carrying bytes to transmit
//   cmd_req / cmd_ack            : 4-phase channel presenting received bytes
//   cmd_data / cmd_err           : received byte and its {parity, framing} flags
// The bridge connects through the slave modport, the host through master.
// ---------------------------------------------------------------------------
interface uart_fc_bridge_if;

   logic       rsp_req;
   logic       rsp_ack;
   logic [7:0] rsp_data;
   logic       cmd_req;
   logic       cmd_ack;
   logic [7:0] cmd_data;
   logic [1:0] cmd_err;

   modport slave (
      input  rsp_req, rsp_data, cmd_ack,
      output rsp_ack, cmd_req, cmd_data, cmd_err
   );

   modport master (
      output rsp_req, rsp_data, cmd_ack,
      input  rsp_ack, cmd_req, cmd_data, cmd_err
   );

endinterface

// File: rtl/uart_fc_bridge.sv
// ---------------------------------------------------------------------------
// uart_fc_bridge
// UART bridge towards an FT232R with RTS/CTS hardware flow control.
//   clk, rst_n  : single clock, asynchronous active-low reset
//   txd         : serial input from the FT232R (synchronized internally)
//   rxd         : registered serial output to the FT232R, idles high
//   rts_n       : FT232R ready to receive (gates TX frame start when P_TX_FC=1)
//   cts_n       : we are ready to receive, driven from RX FIFO level hysteresis
//   bus         : rsp_* TX handshake and cmd_* RX handshake (slave modport)
//   fifo_level  : RX FIFO occupancy
//   ovr_clr     : synchronous clear of the sticky overrun flag
//   overrun     : set when a received frame was dropped on a full FIFO
// ---------------------------------------------------------------------------
module uart_fc_bridge #(
   parameter int P_CLK_FREQ_HZ = 120_000_000,
   parameter int P_BAUD_RATE   = 3_000_000,
   parameter int P_DATA_BITS   = 8,
   parameter int P_PARITY      = 0,
   parameter int P_STOP_BITS   = 1,
   parameter int P_FIFO_DEPTH  = 16,
   parameter int P_CTS_HI      = 12,
   parameter int P_CTS_LO      = 4,
   parameter int P_TX_FC       = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            txd,
   output logic                            rxd,
   input  logic                            rts_n,
   output logic                            cts_n,
   uart_fc_bridge_if.slave                 bus,
   output logic [$clog2(P_FIFO_DEPTH):0]   fifo_level,
   input  logic                            ovr_clr,
   output logic                            overrun
);

   localparam int DIV     = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int CW      = $clog2(DIV);
   localparam int AW      = $clog2(P_FIFO_DEPTH);
   localparam int LW      = AW + 1;
   localparam int TX_BITS = 1 + P_DATA_BITS + ((P_PARITY != 0) ? 1 : 0) + P_STOP_BITS;
   localparam logic [7:0] DATA_MASK = 8'((1 << P_DATA_BITS) - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {CMD_IDLE, CMD_REQ, CMD_WAIT_LO} cmd_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_WAIT_RTS, TX_SEND, TX_ACK} tx_state_t;

   // Serial frame, bit 0 first: start, data LSB first, optional parity, then
   // stop ones. Unused upper bits are 1 so shifting past the end idles high.
   function automatic logic [11:0] build_frame(input logic [7:0] d);
      logic [7:0]  dm;
      logic [11:0] f;
      dm     = d & DATA_MASK;
      f      = 12'hFFF;
      f[8:1] = dm | ~DATA_MASK;
      f[0]   = 1'b0;
      if (P_PARITY != 0) f[P_DATA_BITS + 1] = (P_PARITY == 1) ? ~(^dm) : ^dm;
      return f;
   endfunction

   logic          txd_s1, txd_s2, txd_prev;
   rx_state_t     rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_par_bit;
   logic          rx_par_exp;
   logic          rx_done;
   logic [9:0]    rx_word;

   logic [9:0]    mem [P_FIFO_DEPTH];
   logic [9:0]    head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          fifo_full, fifo_empty, push, pop, drop;

   cmd_state_t    cmd_state;
   logic          cmd_req_r;
   logic [7:0]    cmd_data_r;
   logic [1:0]    cmd_err_r;

   tx_state_t     tx_state;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_idx;
   logic [11:0]   tx_shift;
   logic [11:0]   tx_frame_new;
   logic          rsp_req_prev;
   logic          rsp_ack_r;

   // Two-flop synchronizer on the incoming line plus one more stage used only
   // to spot the falling edge that opens a frame. Reset to idle-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd_s1   <= 1'b1;
         txd_s2   <= 1'b1;
         txd_prev <= 1'b1;
      end else begin
         txd_s1   <= txd;
         txd_s2   <= txd_s1;
         txd_prev <= txd_s2;
      end
   end

   // Unused data bits stay zero, so the reduction covers only real data bits.
   assign rx_par_exp = (P_PARITY == 1) ? ~(^rx_shift) : ^rx_shift;

   // Receiver: the start bit is re-checked half a bit in to reject glitches,
   // then every later bit is sampled a whole bit period apart, i.e. mid-bit.
   // rx_done pulses for one cycle after the stop sample to request a push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_bit <= 1'b0;
         rx_done    <= 1'b0;
         rx_word    <= '0;
      end else begin
         rx_done <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (txd_prev && !txd_s2) rx_state <= RX_START;
            end
            RX_START: begin
               if (rx_cnt == CW'(DIV / 2 - 1)) begin
                  rx_cnt <= '0;
                  if (txd_s2) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_DATA;
                     rx_bit   <= '0;
                     rx_shift <= '0;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt == CW'(DIV - 1)) begin
                  rx_cnt           <= '0;
                  rx_shift[rx_bit] <= txd_s2;
                  rx_bit           <= rx_bit + 3'd1;
                  if (rx_bit == 3'(P_DATA_BITS - 1))
                     rx_state <= (P_PARITY != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            RX_PARITY: begin
               if (rx_cnt == CW'(DIV - 1)) begin
                  rx_cnt     <= '0;
                  rx_par_bit <= txd_s2;
                  rx_state   <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt == CW'(DIV - 1)) begin
                  rx_cnt   <= '0;
                  rx_word  <= {(P_PARITY != 0) && (rx_par_bit != rx_par_exp), ~txd_s2, rx_shift};
                  rx_done  <= 1'b1;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign fifo_full  = (level == LW'(P_FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign push       = rx_done && !fifo_full;
   assign drop       = rx_done && fifo_full;
   assign pop        = (cmd_state == CMD_REQ) && bus.cmd_ack;
   assign head       = mem[rd_ptr];

   // FIFO storage holds {parity_err, framing_err, data}; contents need no reset
   // because nothing reads an entry before it has been written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_word;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves level as is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overrun <= 1'b0;
      else if (drop)    overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
   end

   // CTS hysteresis: back off at the high mark, resume at the low mark, hold
   // in between. Starts deasserted so the FT232R waits until reset is over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          cts_n <= 1'b1;
      else if (level >= LW'(P_CTS_HI))     cts_n <= 1'b1;
      else if (level <= LW'(P_CTS_LO))     cts_n <= 1'b0;
   end

   // Command handshake: the head entry is copied into output registers when
   // cmd_req rises, so data and flags stay frozen for the whole request phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_state  <= CMD_IDLE;
         cmd_req_r  <= 1'b0;
         cmd_data_r <= '0;
         cmd_err_r  <= '0;
      end else begin
         case (cmd_state)
            CMD_IDLE: begin
               if (!fifo_empty) begin
                  cmd_data_r <= head[7:0];
                  cmd_err_r  <= head[9:8];
                  cmd_req_r  <= 1'b1;
                  cmd_state  <= CMD_REQ;
               end
            end
            CMD_REQ: begin
               if (bus.cmd_ack) begin
                  cmd_req_r <= 1'b0;
                  cmd_state <= CMD_WAIT_LO;
               end
            end
            CMD_WAIT_LO: begin
               if (!bus.cmd_ack) cmd_state <= CMD_IDLE;
            end
            default: cmd_state <= CMD_IDLE;
         endcase
      end
   end

   assign tx_frame_new = build_frame(bus.rsp_data);

   // Transmitter: a new frame starts only on a rising rsp_req, so a request
   // left high after its ack never retriggers. Once sending, rts_n is ignored
   // until the frame is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state     <= TX_IDLE;
         tx_cnt       <= '0;
         tx_idx       <= '0;
         tx_shift     <= '1;
         rsp_req_prev <= 1'b0;
         rsp_ack_r    <= 1'b0;
         rxd          <= 1'b1;
      end else begin
         rsp_req_prev <= bus.rsp_req;
         case (tx_state)
            TX_IDLE: begin
               if (bus.rsp_req && !rsp_req_prev) begin
                  tx_cnt <= '0;
                  tx_idx <= '0;
                  if ((P_TX_FC != 0) && rts_n) begin
                     tx_shift <= tx_frame_new;
                     tx_state <= TX_WAIT_RTS;
                  end else begin
                     rxd      <= tx_frame_new[0];
                     tx_shift <= {1'b1, tx_frame_new[11:1]};
                     tx_state <= TX_SEND;
                  end
               end
            end
            TX_WAIT_RTS: begin
               if (!rts_n) begin
                  rxd      <= tx_shift[0];
                  tx_shift <= {1'b1, tx_shift[11:1]};
                  tx_cnt   <= '0;
                  tx_idx   <= '0;
                  tx_state <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (tx_cnt == CW'(DIV - 1)) begin
                  tx_cnt <= '0;
                  if (tx_idx == 4'(TX_BITS - 1)) begin
                     rxd       <= 1'b1;
                     rsp_ack_r <= 1'b1;
                     tx_state  <= TX_ACK;
                  end else begin
                     tx_idx   <= tx_idx + 4'd1;
                     rxd      <= tx_shift[0];
                     tx_shift <= {1'b1, tx_shift[11:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
            TX_ACK: begin
               if (!bus.rsp_req) begin
                  rsp_ack_r <= 1'b0;
                  tx_state  <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign bus.rsp_ack  = rsp_ack_r;
   assign bus.cmd_req  = cmd_req_r;
   assign bus.cmd_data = cmd_data_r;
   assign bus.cmd_err  = cmd_err_r;
   assign fifo_level   = level;

endmodule

// File: tb/tb_uart_fc_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_fc_bridge
// Testbench for uart_fc_bridge. Two instances: dut with default parameters
// (8N1, flow control on) and dut_p with even parity. Receive cases come from
// a vector table; flow control, overrun, glitch, transmit and reset cases are
// written out as sequences.
// ---------------------------------------------------------------------------
module tb_uart_fc_bridge;

   localparam int DIV = 40;

   typedef struct {
      logic       sel;
      logic [7:0] data;
      logic       has_par;
      logic       pbit;
      logic       sbit;
      logic [7:0] exp_data;
      logic [1:0] exp_err;
   } rx_vec_t;

   logic       clk;
   logic       rst_n;
   logic       txd, txd_p;
   logic       rxd, rxd_p;
   logic       rts_n, rts_n_p;
   logic       cts_n, cts_n_p;
   logic       ovr_clr, ovr_clr_p;
   logic       overrun, overrun_p;
   logic [4:0] fifo_level, fifo_level_p;
   logic       sel;
   logic       m_cmd_req;
   logic [7:0] m_cmd_data;
   logic [1:0] m_cmd_err;
   logic [4:0] m_level;

   int         passed;
   int         total;
   rx_vec_t    vecs [9];

   uart_fc_bridge_if bus ();
   uart_fc_bridge_if bus_p ();

   uart_fc_bridge dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .txd        (txd),
      .rxd        (rxd),
      .rts_n      (rts_n),
      .cts_n      (cts_n),
      .bus        (bus),
      .fifo_level (fifo_level),
      .ovr_clr    (ovr_clr),
      .overrun    (overrun)
   );

   uart_fc_bridge #(.P_PARITY(2)) dut_p (
      .clk        (clk),
      .rst_n      (rst_n),
      .txd        (txd_p),
      .rxd        (rxd_p),
      .rts_n      (rts_n_p),
      .cts_n      (cts_n_p),
      .bus        (bus_p),
      .fifo_level (fifo_level_p),
      .ovr_clr    (ovr_clr_p),
      .overrun    (overrun_p)
   );

   // Receive-side view of whichever instance the current case targets.
   assign m_cmd_req  = sel ? bus_p.cmd_req  : bus.cmd_req;
   assign m_cmd_data = sel ? bus_p.cmd_data : bus.cmd_data;
   assign m_cmd_err  = sel ? bus_p.cmd_err  : bus.cmd_err;
   assign m_level    = sel ? fifo_level_p   : fifo_level;

   // 100 MHz-style clock, period 10 time units.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some wait is never satisfied.
   initial begin
      #900_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic setTx(input logic s, input logic v);
      if (s) txd_p = v;
      else   txd   = v;
   endtask

   task automatic setAck(input logic s, input logic v);
      if (s) bus_p.cmd_ack = v;
      else   bus.cmd_ack   = v;
   endtask

   // Send one serial frame, each bit DIV cycles, and leave the line idle high.
   task automatic applyStimulus(input logic s, input logic [7:0] d, input logic has_par,
                                input logic pbit, input logic sbit);
      logic [10:0] bits;
      int          n;
      bits = {sbit, (has_par ? pbit : sbit), d, 1'b0};
      n    = has_par ? 11 : 10;
      for (int i = 0; i < n; i++) begin
         setTx(s, bits[i]);
         repeat (DIV) @(negedge clk);
      end
      setTx(s, 1'b1);
   endtask

   // Complete one cmd handshake and check the presented byte and flags.
   task automatic popCheck(input logic s, input string name, input logic [7:0] exp_data,
                           input logic [1:0] exp_err);
      int w;
      sel = s;
      w   = 0;
      while (m_cmd_req !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      checkOutput({name, "_req"}, m_cmd_req, 1);
      checkOutput({name, "_data"}, m_cmd_data, exp_data);
      checkOutput({name, "_err"}, m_cmd_err, exp_err);
      setAck(s, 1'b1);
      w = 0;
      while (m_cmd_req !== 1'b0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      checkOutput({name, "_req_drop"}, m_cmd_req, 0);
      setAck(s, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   // Capture a TX frame on rxd, sampling mid-bit, and count cycles from the
   // start bit to rsp_ack. Optionally drops rts_n partway through.
   task automatic txCapture(input int rts_off_at, output logic [9:0] bits, output int ack_cycles);
      int w;
      int cnt;
      bits       = '1;
      ack_cycles = -1;
      w          = 0;
      while (rxd !== 1'b0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      cnt = 0;
      while (cnt < 500 && bus.rsp_ack !== 1'b1) begin
         @(negedge clk);
         cnt++;
         if ((cnt % DIV) == (DIV / 2) && cnt < 10 * DIV) bits[cnt / DIV] = rxd;
         if (cnt == rts_off_at) rts_n = 1'b1;
      end
      if (bus.rsp_ack === 1'b1) ack_cycles = cnt;
   endtask

   initial begin
      logic [9:0] tx_bits;
      int         ack_cycles;
      int         bad;

      passed        = 0;
      total         = 0;
      sel           = 1'b0;
      rst_n         = 1'b0;
      txd           = 1'b1;
      txd_p         = 1'b1;
      rts_n         = 1'b0;
      rts_n_p       = 1'b0;
      ovr_clr       = 1'b0;
      ovr_clr_p     = 1'b0;
      bus.rsp_req   = 1'b0;
      bus.rsp_data  = 8'h00;
      bus.cmd_ack   = 1'b0;
      bus_p.rsp_req  = 1'b0;
      bus_p.rsp_data = 8'h00;
      bus_p.cmd_ack  = 1'b0;

      //          sel   data   par   pbit  sbit  exp    err
      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 2'b00};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00};
      vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b00};
      vecs[3] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b01};
      vecs[4] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 2'b10};
      vecs[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 2'b00};
      vecs[6] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 2'b00};
      vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 2'b01};
      vecs[8] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 2'b11};

      // Reset values
      repeat (5) @(negedge clk);
      checkOutput("rst_rxd", rxd, 1);
      checkOutput("rst_cts_n", cts_n, 1);
      checkOutput("rst_rsp_ack", bus.rsp_ack, 0);
      checkOutput("rst_cmd_req", bus.cmd_req, 0);
      checkOutput("rst_cmd_data", bus.cmd_data, 0);
      checkOutput("rst_cmd_err", bus.cmd_err, 0);
      checkOutput("rst_fifo_level", fifo_level, 0);
      checkOutput("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("cts_after_release", cts_n, 0);
      @(negedge clk);

      // Table-driven receive cases
      for (int i = 0; i < 9; i++) begin
         sel = vecs[i].sel;
         applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].has_par, vecs[i].pbit, vecs[i].sbit);
         checkOutput($sformatf("rx%0d_level_full", i), m_level, 1);
         popCheck(vecs[i].sel, $sformatf("rx%0d", i), vecs[i].exp_data, vecs[i].exp_err);
         checkOutput($sformatf("rx%0d_level_empty", i), m_level, 0);
      end

      // Start-bit glitch, then a normal frame
      sel = 1'b0;
      txd = 1'b0;
      repeat (10) @(negedge clk);
      txd = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("glitch_level", fifo_level, 0);
      checkOutput("glitch_cmd_req", bus.cmd_req, 0);
      applyStimulus(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
      checkOutput("post_glitch_level", fifo_level, 1);
      popCheck(1'b0, "post_glitch", 8'h96, 2'b00);

      // Fill past capacity without acking: CTS hysteresis and overrun
      for (int k = 0; k < 17; k++) begin
         applyStimulus(1'b0, 8'(8'h10 + k), 1'b0, 1'b0, 1'b1);
         if (k == 10) checkOutput("cts_at_11", cts_n, 0);
         if (k == 11) checkOutput("cts_at_12", cts_n, 1);
         if (k == 15) checkOutput("ovr_at_16", overrun, 0);
      end
      checkOutput("full_level", fifo_level, 16);
      checkOutput("ovr_at_17", overrun, 1);
      for (int k = 0; k < 16; k++) begin
         popCheck(1'b0, $sformatf("fifo%0d", k), 8'(8'h10 + k), 2'b00);
         if (k == 10) checkOutput("cts_level5", cts_n, 1);
         if (k == 11) checkOutput("cts_level4", cts_n, 0);
      end
      checkOutput("drain_level", fifo_level, 0);
      checkOutput("drain_cmd_req", bus.cmd_req, 0);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      @(negedge clk);
      checkOutput("ovr_clr", overrun, 0);

      // TX gated by rts_n, rts_n dropped mid-frame
      rts_n        = 1'b1;
      bus.rsp_data = 8'h3C;
      bus.rsp_req  = 1'b1;
      bad          = 0;
      repeat (100) begin
         @(negedge clk);
         if (rxd !== 1'b1 || bus.rsp_ack !== 1'b0) bad++;
      end
      checkOutput("tx_wait_rts", bad, 0);
      rts_n = 1'b0;
      txCapture(100, tx_bits, ack_cycles);
      checkOutput("tx_3c_frame", tx_bits, 10'b1001111000);
      checkOutput("tx_3c_ack_cycles", ack_cycles, 400);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (rxd !== 1'b1 || bus.rsp_ack !== 1'b1) bad++;
      end
      checkOutput("tx_no_retrigger", bad, 0);
      bus.rsp_req = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("tx_ack_drop", bus.rsp_ack, 0);

      // TX with rts_n already asserted
      rts_n        = 1'b0;
      bus.rsp_data = 8'h81;
      bus.rsp_req  = 1'b1;
      txCapture(-1, tx_bits, ack_cycles);
      checkOutput("tx_81_frame", tx_bits, 10'b1100000010);
      checkOutput("tx_81_ack_cycles", ack_cycles, 400);
      bus.rsp_req = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("tx_81_ack_drop", bus.rsp_ack, 0);

      // Reset in the middle of a TX and an RX frame
      bus.rsp_data = 8'h00;
      bus.rsp_req  = 1'b1;
      txd          = 1'b0;
      repeat (150) @(negedge clk);
      checkOutput("pre_reset_rxd", rxd, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_rxd", rxd, 1);
      checkOutput("mid_rst_rsp_ack", bus.rsp_ack, 0);
      checkOutput("mid_rst_level", fifo_level, 0);
      checkOutput("mid_rst_cmd_req", bus.cmd_req, 0);
      checkOutput("mid_rst_cts_n", cts_n, 1);
      txd         = 1'b1;
      bus.rsp_req = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad   = 0;
      repeat (600) begin
         @(negedge clk);
         if (bus.cmd_req !== 1'b0 || rxd !== 1'b1 || fifo_level !== 5'd0 || bus.rsp_ack !== 1'b0) bad++;
      end
      checkOutput("post_rst_quiet", bad, 0);
      checkOutput("post_rst_cts_n", cts_n, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
